// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters.
// A grant lasts for up to MAX_BURST beats, and a full FIFO stalls the burst.
module fifo_wr_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned IW        = $clog2(NREQ),
    parameter int unsigned BW        = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_dat_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [NREQ-1:0]       gnt_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_wen_o,
    output logic [WIDTH-1:0]      fifo_dat_o,
    output logic                  busy_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            busy_q, busy_d;

    logic            any_valid;
    logic            owner_valid;
    logic            beat;
    logic            burst_end;
    logic [IW-1:0]   pick_base;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [NREQ-1:0] pick_onehot;
    logic [WIDTH-1:0] sel_dat;

    assign any_valid   = |req_valid_i;
    assign owner_valid = req_valid_i[owner_q];
    assign beat        = (state_q == S_BURST) && owner_valid && !fifo_full_i;
    assign burst_end   = (beat && (bcnt_q == BW'(MAX_BURST - 1))) || !owner_valid;

    // A release searches from the current owner, so it loses to any other valid requester.
    assign pick_base = (state_q == S_BURST) ? owner_q : last_q;

    // Round-robin search starting just after pick_base, wrapping at NREQ.
    always_comb begin
        int unsigned cand;
        cand       = 0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(pick_base) + i) % NREQ;
            if (!pick_found && req_valid_i[IW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    assign pick_onehot = NREQ'(1) << pick_idx;

    // Owner's data slice.
    always_comb begin
        sel_dat = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (owner_q == IW'(k)) begin
                sel_dat = req_dat_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_dat_o  = (|gnt_q) ? sel_dat : '0;
    assign fifo_wen_o  = beat;
    assign req_ready_o = beat ? gnt_q : '0;
    assign gnt_o       = gnt_q;
    assign busy_o      = busy_q;

    // Next-state logic: grant, burst count and round-robin history.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (any_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = pick_onehot;
                    bcnt_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (beat) begin
                    bcnt_d = bcnt_q + BW'(1);
                end
                if (burst_end) begin
                    last_d = owner_q;
                    bcnt_d = '0;
                    if (any_valid) begin
                        owner_d = pick_idx;
                        gnt_d   = pick_onehot;
                    end else begin
                        gnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d == S_BURST);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            bcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule
